// File: rtl/stall_mem_resp_pkg.sv
// Shared types and widths for the stall_mem_resp fixed-latency memory responder.
package stall_mem_resp_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {RD, WR} op_t;
endpackage

// File: rtl/stall_mem_resp_if.sv
// Request/response bus between a requester (master) and stall_mem_resp (slave).
interface stall_mem_resp_if;
  import stall_mem_resp_pkg::*;

  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] DataIn;
  logic              Rd;
  logic              Wr;
  logic              createdump;
  logic [DATA_W-1:0] DataOut;
  logic              Done;
  logic              Stall;
  logic              CacheHit;
  logic              err;

  modport master (output Addr, DataIn, Rd, Wr, createdump,
                  input  DataOut, Done, Stall, CacheHit, err);
  modport slave  (input  Addr, DataIn, Rd, Wr, createdump,
                  output DataOut, Done, Stall, CacheHit, err);
endinterface

// File: rtl/stall_mem_resp_array.sv
// Word storage: one combinational read port and one synchronous write port sharing an index.
module stall_mem_resp_array
  import stall_mem_resp_pkg::*;
#(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);
  logic [DATA_W-1:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/stall_mem_resp.sv
// Fixed-latency memory responder with Stall/Done handshake.
// Optional one-entry read hit buffer enabled by macro STALL_MEM_RESP_HITBUF_EN.
module stall_mem_resp
  import stall_mem_resp_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  stall_mem_resp_if.slave     bus
);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t             state_p1;
  op_t                op_p1;
  logic [3:0]         cnt_p1;
  logic               done_p1;
  logic               hit_p1;
  logic               mis_p1;
  logic               err_both_p1;
  logic [DEPTH_W-1:0] idx_p1;
  logic [DATA_W-1:0]  wdata_p1;

  logic              sample, rd_req, wr_req, take, hit_now;
  logic              rd_ok, wr_ok;
  logic [DATA_W-1:0] arr_rdata, resp_data;
  logic              unused_bits;

  // Requests are accepted when idle or in the completion cycle of the previous one.
  assign sample = (state_p1 == IDLE) || done_p1;
  assign rd_req = bus.Rd && !bus.Wr;
  assign wr_req = bus.Wr && !bus.Rd;
  assign take   = sample && (rd_req || wr_req);

  assign rd_ok = done_p1 && (op_p1 == RD) && !mis_p1;
  assign wr_ok = done_p1 && (op_p1 == WR) && !mis_p1;

  // Stage p0 -> p1: request capture and completion countdown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1    <= IDLE;
      op_p1       <= RD;
      cnt_p1      <= '0;
      done_p1     <= 1'b0;
      hit_p1      <= 1'b0;
      mis_p1      <= 1'b0;
      err_both_p1 <= 1'b0;
    end else begin
      err_both_p1 <= sample && bus.Rd && bus.Wr;
      if (take) begin
        state_p1 <= BUSY;
        op_p1    <= rd_req ? RD : WR;
        mis_p1   <= bus.Addr[0];
        hit_p1   <= hit_now;
        cnt_p1   <= hit_now ? 4'd0 : CNT_LOAD;
        done_p1  <= hit_now;
      end else if (done_p1) begin
        state_p1 <= IDLE;
        cnt_p1   <= '0;
        done_p1  <= 1'b0;
        hit_p1   <= 1'b0;
      end else if (state_p1 == BUSY) begin
        cnt_p1  <= cnt_p1 - 4'd1;
        done_p1 <= (cnt_p1 == 4'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      idx_p1   <= bus.Addr[DEPTH_W:1];
      wdata_p1 <= bus.DataIn;
    end
  end

  stall_mem_resp_array #(.DEPTH_W(DEPTH_W)) u_array (
    .clk   (clk),
    .we    (wr_ok),
    .addr  (idx_p1),
    .wdata (wdata_p1),
    .rdata (arr_rdata)
  );

`ifdef STALL_MEM_RESP_HITBUF_EN
  logic               buf_vld;
  logic [DEPTH_W-1:0] buf_idx;
  logic [DATA_W-1:0]  buf_data;

  assign hit_now   = rd_req && !bus.Addr[0] && buf_vld && (buf_idx == bus.Addr[DEPTH_W:1]);
  assign resp_data = hit_p1 ? buf_data : arr_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       buf_vld <= 1'b0;
    else if (rd_ok) buf_vld <= 1'b1;
  end

  // Buffer data tracks committed writes so a later hit never returns stale data.
  always_ff @(posedge clk) begin
    if (rd_ok) begin
      buf_idx  <= idx_p1;
      buf_data <= resp_data;
    end else if (wr_ok && (idx_p1 == buf_idx)) begin
      buf_data <= wdata_p1;
    end
  end

  assign bus.CacheHit = done_p1 && hit_p1;
`else
  assign hit_now      = 1'b0;
  assign resp_data    = arr_rdata;
  assign bus.CacheHit = 1'b0;
`endif

  assign bus.Stall   = (state_p1 == BUSY);
  assign bus.Done    = done_p1;
  assign bus.DataOut = rd_ok ? resp_data : '0;
  assign bus.err     = (done_p1 && mis_p1) || err_both_p1;

  assign unused_bits = ^{bus.createdump, bus.Addr[ADDR_W-1:DEPTH_W+1], hit_p1};
endmodule

// File: doc/stall_mem_resp.md
STALL_MEM_RESP -- requirements
Module: stall_mem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request sample to Done (legal range 2..15).
REQ-002 SHALL have parameter DEPTH_W, default 10, meaning log2 of storage depth in 16-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Addr  input  16  byte address of request.
REQ-006 SHALL have port DataIn  input  16  write data.
REQ-007 SHALL have port Rd  input  1  read request.
REQ-008 SHALL have port Wr  input  1  write request.
REQ-009 SHALL have port createdump  input  1  accepted, no functional effect.
REQ-010 SHALL have port DataOut  output  16  read data, valid only when Done=1.
REQ-011 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port Stall  output  1  busy; new requests ignored.
REQ-013 SHALL have port CacheHit  output  1  completion served from hit buffer.
REQ-014 SHALL have port err  output  1  one-cycle error pulse.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY, plus a down-counter of width 4.
REQ-016 SHALL sample a request at the rising edge ending cycle N when state is IDLE or Done=1 and exactly one of Rd/Wr is high; it then captures Addr, DataIn and op, loads the counter and enters BUSY.
REQ-017 SHALL drive Stall=1 in cycles N+1..N+LATENCY inclusive and Done=1 only in cycle N+LATENCY; outside these cycles Stall=0 and Done=0.
REQ-018 SHALL return to IDLE after the Done cycle unless a new request is sampled in that cycle, which gives back-to-back throughput of one request per LATENCY cycles.
REQ-019 SHALL ignore Rd/Wr/Addr/DataIn changes while BUSY and Done=0.
REQ-020 SHALL index storage with Addr[DEPTH_W:1]; higher address bits alias (wrap-around).
REQ-021 SHALL drive DataOut in a read Done cycle with storage contents at the captured index as of that cycle; DataOut SHALL be 0 whenever Done=0 and in write Done cycles.
REQ-022 SHALL commit a write to storage at the rising edge ending its Done cycle.
REQ-023 SHALL treat a captured Addr[0]=1 as misaligned: the transaction completes with normal timing, err=1 in the Done cycle, no write is performed, and DataOut=0.
REQ-024 SHALL, when Rd and Wr are both high at a sampling edge, capture no request, stay or return to IDLE, and pulse err=1 in the next cycle.
REQ-025 SHALL, when neither Rd nor Wr is high at a sampling edge, remain or return to IDLE.

Reset
REQ-026 SHALL, on rst low, immediately force state=IDLE, counter=0, Stall=0, Done=0, CacheHit=0, err=0, DataOut=0, abandon any in-flight transaction, and drop any pending write.
REQ-027 SHALL NOT reset storage contents; the bench initialises storage.

Configuration
REQ-028 SHALL provide macro STALL_MEM_RESP_HITBUF_EN.
REQ-029 SHALL, with STALL_MEM_RESP_HITBUF_EN defined, keep a one-entry buffer (valid, index, data) loaded on each aligned read completion.
REQ-030 SHALL, with the macro defined, complete an aligned read whose index matches the valid buffer entry at cycle N+1 with Done=1, CacheHit=1 and the buffered data.
REQ-031 SHALL, with the macro defined, update the buffer data when a committed write matches its index, and clear the valid bit on reset.
REQ-032 SHALL, without STALL_MEM_RESP_HITBUF_EN, tie CacheHit to 0 and apply full LATENCY to every request.

Structure
REQ-033 SHALL place the state enum, op enum (RD, WR), DATA_W=16 and ADDR_W=16 in package stall_mem_resp_pkg.
REQ-034 SHALL instantiate one sub-module, stall_mem_resp_array: 2^DEPTH_W x 16 storage with one combinational read port and one synchronous write port.

Verification
REQ-035 SHALL cover aligned read: storage[5]=0xBEEF, Rd with Addr=0x000A at N -> Stall=1 during N+1..N+4, Done=1 with DataOut=0xBEEF at N+4 (LATENCY=4).
REQ-036 SHALL cover write-then-read: Wr Addr=0x0010 DataIn=0x1234, then back-to-back Rd of 0x0010 sampled in the write Done cycle -> read Done 4 cycles later with DataOut=0x1234.
REQ-037 SHALL cover error cases: Rd Addr=0x0003 -> err=1 and DataOut=0 in Done cycle; Rd and Wr both high -> no Stall, err=1 next cycle.
REQ-038 SHALL cover reset mid-transaction: rst low at N+2 of a write to 0x0020 -> Stall=0 and Done=0 immediately, and a later read of 0x0020 returns the old value.
REQ-039 SHALL cover hit buffer with STALL_MEM_RESP_HITBUF_EN defined: repeat Rd of 0x000A -> Done=1 and CacheHit=1 at N+1; without the macro, Done at N+4 and CacheHit=0.
REQ-040 SHALL cover wrap-around: Rd of 0x080A with DEPTH_W=10 -> returns storage[5].
